// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, with a single-entry tagged response slot.
// Optional signed-overflow output rsp_ovf is built only when ADDER_ARB_OVF_EN is defined.

module adder #(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic [OPERAND_LENGTH-1:0] opd1,
  input  logic [OPERAND_LENGTH-1:0] opd2,
  input  logic [3:0]                alu_op_select,
  output logic [OPERAND_LENGTH-1:0] result
);
  // Only the subtract encoding differs from add; carry-out is dropped.
  assign result = (alu_op_select == 4'b1000) ? (opd1 - opd2) : (opd1 + opd2);
endmodule

module adder_arbiter #(
  parameter int OPERAND_LENGTH = 32,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*OPERAND_LENGTH-1:0] req_opd1,
  input  logic [NUM_REQ*OPERAND_LENGTH-1:0] req_opd2,
  input  logic [NUM_REQ-1:0]                req_sub,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [OPERAND_LENGTH-1:0]         rsp_result
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                              rsp_ovf
`endif
);

  // Handshake: a request transfers when req_valid[i] & req_ready[i]; the
  // response transfers when rsp_valid & rsp_ready. req_ready is combinational
  // on req_valid and rsp_ready, so req_valid must never depend on req_ready.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                    state;
  logic [ID_W-1:0]           last_grant;
  logic                      slot_free;
  logic                      grant_any;
  logic                      found;
  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           gid;
  logic [NUM_REQ-1:0]        onehot;
  logic [OPERAND_LENGTH-1:0] opd1_arr [NUM_REQ];
  logic [OPERAND_LENGTH-1:0] opd2_arr [NUM_REQ];
  logic [OPERAND_LENGTH-1:0] sel_opd1;
  logic [OPERAND_LENGTH-1:0] sel_opd2;
  logic                      sel_sub;
  logic [OPERAND_LENGTH-1:0] sum;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opd1_arr[g] = req_opd1[g*OPERAND_LENGTH +: OPERAND_LENGTH];
    assign opd2_arr[g] = req_opd2[g*OPERAND_LENGTH +: OPERAND_LENGTH];
  end

  assign rsp_valid = (state == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // Search upward from last_grant+1, wrapping at NUM_REQ-1; first hit wins.
  always_comb begin
    found  = 1'b0;
    gid    = last_grant;
    onehot = '0;
    ptr    = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      ptr = (ptr == ID_W'(NUM_REQ - 1)) ? '0 : ptr + ID_W'(1);
      if (!found && req_valid[ptr]) begin
        found       = 1'b1;
        gid         = ptr;
        onehot[ptr] = 1'b1;
      end
    end
  end

  assign grant_any = found && slot_free && !rst;
  assign req_ready = grant_any ? onehot : '0;

  assign sel_opd1 = opd1_arr[gid];
  assign sel_opd2 = opd2_arr[gid];
  assign sel_sub  = req_sub[gid];

  adder #(.OPERAND_LENGTH(OPERAND_LENGTH)) u_adder (
    .opd1          (sel_opd1),
    .opd2          (sel_opd2),
    .alu_op_select ({sel_sub, 3'b000}),
    .result        (sum)
  );

`ifdef ADDER_ARB_OVF_EN
  logic [OPERAND_LENGTH-1:0] opd2_eff;
  logic                      ovf_next;
  assign opd2_eff = sel_opd2 ^ {OPERAND_LENGTH{sel_sub}};
  assign ovf_next = (sel_opd1[OPERAND_LENGTH-1] == opd2_eff[OPERAND_LENGTH-1]) &&
                    (sum[OPERAND_LENGTH-1] != sel_opd1[OPERAND_LENGTH-1]);
`endif

  // A grant always (re)loads the slot, which also covers drain-and-refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      if (grant_any) begin
        state      <= FULL;
        last_grant <= gid;
        rsp_id     <= gid;
        rsp_result <= sum;
`ifdef ADDER_ARB_OVF_EN
        rsp_ovf    <= ovf_next;
`endif
      end else if (state == FULL && rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, add, round-robin, backpressure, wrap, overflow, mid-op reset.
// Overflow checks are compiled only with ADDER_ARB_OVF_EN.

module tb_adder_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_opd1;
  logic [N*W-1:0] req_opd2;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
`ifdef ADDER_ARB_OVF_EN
  logic           rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.OPERAND_LENGTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_opd1   (req_opd1),
    .req_opd2   (req_opd2),
    .req_sub    (req_sub),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_opd1[i*W +: W] = a;
    req_opd2[i*W +: W] = b;
    req_sub[i]         = s;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_opd1  = '0;
    req_opd2  = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
`ifdef ADDER_ARB_OVF_EN
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", rsp_ovf); end
`endif
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_basic_add();
    @(negedge clk);
    set_req(0, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL add_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL add_result got %0d exp 12", rsp_result); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL add_idle_ready got %b exp 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(10 * i), 32'(i), 1'b0);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      int e;
      e = c % N;
      exp_rdy = 4'(1 << e);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, req_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e)) begin errors++; $display("FAIL rr_id%0d got v=%b id=%0d exp v=1 id=%0d", c, rsp_valid, rsp_id, e); end
      checks++; if (rsp_result !== 32'(11 * e)) begin errors++; $display("FAIL rr_result%0d got %0d exp %0d", c, rsp_result, 11 * e); end
      @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    // last_grant is 1 here, so req0 wins after searching 2,3,0.
    @(negedge clk);
    set_req(0, 32'd1, 32'd1, 1'b0);
    set_req(2, 32'd100, 32'd23, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_fill got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd2) begin
        errors++; $display("FAIL bp_hold%0d got v=%b id=%0d r=%0d exp v=1 id=0 r=2", c, rsp_valid, rsp_id, rsp_result);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got %b exp 0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd123) begin
      errors++; $display("FAIL bp_result got v=%b id=%0d r=%0d exp v=1 id=2 r=123", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_sub_wrap();
    // last_grant is 2: req1 alone, then req3 alone, back to back.
    @(negedge clk);
    set_req(1, 32'd0, 32'd1, 1'b1);
    set_req(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub_grant got %b exp 0010", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd1 || rsp_result !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_wrap got id=%0d r=%h exp id=1 r=ffffffff", rsp_id, rsp_result);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL addwrap_grant got %b exp 1000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL add_wrap got v=%b id=%0d r=%h exp v=1 id=3 r=0", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

`ifdef ADDER_ARB_OVF_EN
  task automatic test_overflow();
    logic [W-1:0] a_tab [3];
    logic [W-1:0] b_tab [3];
    logic         s_tab [3];
    logic [W-1:0] r_tab [3];
    logic         o_tab [3];
    a_tab = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd3};
    b_tab = '{32'd1,         32'd1,         32'd5};
    s_tab = '{1'b0,          1'b1,          1'b1};
    r_tab = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    o_tab = '{1'b1,          1'b1,          1'b0};
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_req(0, a_tab[c], b_tab[c], s_tab[c]);
      req_valid = 4'b0001;
      @(posedge clk); #1;
      checks++; if (rsp_result !== r_tab[c] || rsp_ovf !== o_tab[c]) begin
        errors++; $display("FAIL ovf%0d got r=%h o=%b exp r=%h o=%b", c, rsp_result, rsp_ovf, r_tab[c], o_tab[c]);
      end
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask
`endif

  task automatic test_mid_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd1, 1'b0);
    req_valid = '1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mr_full got %b exp 1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mr_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mr_first got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd2) begin
      errors++; $display("FAIL mr_rsp got v=%b id=%0d r=%0d exp v=1 id=0 r=2", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_round_robin();
    test_backpressure();
    test_sub_wrap();
`ifdef ADDER_ARB_OVF_EN
    test_overflow();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer sharing one `adder` instance among `NUM_REQ` requesters.
- Each requester presents an operand pair and an add/sub select over a valid/ready handshake.
- The arbiter grants one requester per cycle and drives the shared adder with that requester's operands.
- The result is registered into a single-entry response slot tagged with the requester index.
- The block sits between the ALU's issuing units and the shared adder.

## Interface
Parameters:
- `OPERAND_LENGTH`, 32, operand/result width passed to `adder`
- `NUM_REQ`, 4, number of requesters; legal values 2..8
- `ID_W`, 2, requester index width; must equal ceil(log2(`NUM_REQ`))

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  `NUM_REQ`  per-requester request valid
- `req_opd1`  in  `NUM_REQ*OPERAND_LENGTH`  flattened operand 1; requester i at bits [i*OPERAND_LENGTH +: OPERAND_LENGTH]
- `req_opd2`  in  `NUM_REQ*OPERAND_LENGTH`  flattened operand 2, same packing
- `req_sub`  in  `NUM_REQ`  1 = subtract (opd1-opd2), 0 = add
- `req_ready`  out  `NUM_REQ`  one-hot grant; the transfer for requester i occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  response slot full
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  `ID_W`  index of the requester that produced the response
- `rsp_result`  out  `OPERAND_LENGTH`  adder result, modulo 2^OPERAND_LENGTH
- `rsp_ovf`  out  1  signed overflow flag; present only with `ADDER_ARB_OVF_EN`

## Operation
- **Shared adder:** one `adder` instance.
  - `opd1`/`opd2` are muxed from the granted requester.
  - `alu_op_select` = {granted `req_sub`, 3'b000}.
- **Slot availability:** `slot_free` = !`rsp_valid` | `rsp_ready`.
- **Grant rule:**
  - `req_ready` is all-zero when `slot_free`=0.
  - Otherwise it is one-hot on the first asserted `req_valid` bit searching upward from `last_grant+1`, wrapping at `NUM_REQ-1` → 0.
  - With no valid request, `req_ready` is all-zero.
- **Combinational dependency:** `req_ready` depends on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **Response state machine:**
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `rsp_ready` with no grant.
  - FULL→FULL on `rsp_ready` with a grant: the slot is reloaded in the same cycle.
  - FULL with !`rsp_ready` holds `rsp_id`/`rsp_result`/`rsp_ovf` stable.
- **On a grant to requester i:**
  - `last_grant` ← i.
  - `rsp_id` ← i.
  - `rsp_result` ← adder output.
- **Arithmetic:** width is `OPERAND_LENGTH`. Carry-out is discarded; results wrap (0xFFFFFFFF+1 = 0; 0-1 = 0xFFFFFFFF).
- **Requester stability:** a requester holds its operands and `req_sub` stable while `req_valid`=1 and it is not granted. The arbiter does not check this.
- **Reset:** asynchronous assertion at any time returns the block to its reset state. An in-flight or unconsumed response is discarded.

## Timing
- **Reset values:**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_ovf`=0.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready`=0 while `rst`=1.
- **Latency:** grant in cycle N → `rsp_valid`=1 with data from cycle N+1.
- **Throughput:** one operation per cycle while `rsp_ready` is held 1.
- **Backpressure:** with `rsp_ready`=0 and the slot FULL, no grant is issued and all `req_ready`=0.
- **Fairness:** worst-case wait for a continuously valid requester is `NUM_REQ-1` grants.
- **Reset release:** first grant possible in the first cycle after `rst` deasserts.

## Configuration
- **Macro:** `ADDER_ARB_OVF_EN`.
- **Defined:**
  - `rsp_ovf` port exists and is registered with the result.
  - Let a = opd1, b' = opd2 ^ {OPERAND_LENGTH{sub}}, r = result.
  - `rsp_ovf` = (a[MSB]==b'[MSB]) & (r[MSB]!=a[MSB]).
- **Undefined:** `rsp_ovf` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Basic add:** after reset, req0 valid with 5+7, `rsp_ready`=1 → `req_ready`=4'b0001 that cycle; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12.
- **Round-robin:** all four valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0,1 on consecutive cycles. Response stream ids follow the same order, one per cycle.
- **Backpressure:** slot FULL with `rsp_ready`=0 for 3 cycles while req2 is valid → `req_ready`=0 and response held unchanged. On `rsp_ready`=1, req2 is granted that same cycle, and its result follows one cycle later.
- **Subtract wrap:** req1 with `req_sub`=1, 0−1 → `rsp_result`=0xFFFFFFFF. 0xFFFFFFFF+1 add → 0.
- **Overflow flag (with `ADDER_ARB_OVF_EN`):**
  - 0x7FFFFFFF+1 → `rsp_ovf`=1.
  - 0x80000000−1 → `rsp_ovf`=1.
  - 3−5 → `rsp_ovf`=0 with result 0xFFFFFFFE.
- **Mid-operation reset:** assert `rst` while the slot is FULL and requests are pending → `rsp_valid`=0 and `req_ready`=0 immediately. After release, requester 0 wins first among all valid.
